// File: rtl/host_seg_display_pkg.sv
// Shared types and constants for the host-mapped 7-segment display controller:
// scan FSM states, register word offsets, CTRL bit positions and glyph patterns.
package host_seg_display_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_t;

   // Word offsets, i.e. HOST_ADD[2:1] inside the 8-byte window
   localparam logic [1:0] OFF_DIG_LO = 2'd0;
   localparam logic [1:0] OFF_DIG_HI = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_MASKS  = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_HEX = 1;

   // Segment order {a,b,c,d,e,f,g}
   localparam logic [6:0] GLYPH_0 = 7'b1111110;
   localparam logic [6:0] GLYPH_1 = 7'b0110000;
   localparam logic [6:0] GLYPH_2 = 7'b1101101;
   localparam logic [6:0] GLYPH_3 = 7'b1111001;
   localparam logic [6:0] GLYPH_4 = 7'b0110011;
   localparam logic [6:0] GLYPH_5 = 7'b1011011;
   localparam logic [6:0] GLYPH_6 = 7'b1011111;
   localparam logic [6:0] GLYPH_7 = 7'b1110000;
   localparam logic [6:0] GLYPH_8 = 7'b1111111;
   localparam logic [6:0] GLYPH_9 = 7'b1111011;
   localparam logic [6:0] GLYPH_A = 7'b1110111;
   localparam logic [6:0] GLYPH_B = 7'b0011111;
   localparam logic [6:0] GLYPH_C = 7'b1001110;
   localparam logic [6:0] GLYPH_D = 7'b0111101;
   localparam logic [6:0] GLYPH_E = 7'b1001111;
   localparam logic [6:0] GLYPH_F = 7'b1000111;
   localparam logic [6:0] GLYPH_OFF = 7'b0000000;

endpackage

// File: rtl/host_seg_display_if.sv
// Host static-memory bus as seen by the display controller.
interface host_seg_display_if #(
   parameter int ADDR_W = 20
);
   // Strobe semantics: a write is one falling edge of HOST_nWE while HOST_nCS is low and
   // HOST_nOE is high; HOST_ADD/HDI stay stable for the whole strobe. A read is any cycle
   // with HOST_nCS and HOST_nOE low; rd_hit/rd_data answer one clk later.
   logic              HOST_nCS;
   logic              HOST_nWE;
   logic              HOST_nOE;
   logic [ADDR_W-1:0] HOST_ADD;
   logic [15:0]       HDI;
   logic [15:0]       rd_data;
   logic              rd_hit;

   modport master (
      output HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI,
      input  rd_data, rd_hit
   );

   modport slave (
      input  HOST_nCS, HOST_nWE, HOST_nOE, HOST_ADD, HDI,
      output rd_data, rd_hit
   );
endinterface

// File: rtl/host_seg_display_decode.sv
// Combinational nibble-to-glyph decoder; A-F light only in hex mode.
module seg7_decode
   import host_seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = GLYPH_OFF;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = hex_mode ? GLYPH_A : GLYPH_OFF;
         4'hB: glyph = hex_mode ? GLYPH_B : GLYPH_OFF;
         4'hC: glyph = hex_mode ? GLYPH_C : GLYPH_OFF;
         4'hD: glyph = hex_mode ? GLYPH_D : GLYPH_OFF;
         4'hE: glyph = hex_mode ? GLYPH_E : GLYPH_OFF;
         4'hF: glyph = hex_mode ? GLYPH_F : GLYPH_OFF;
         default: glyph = GLYPH_OFF;
      endcase
   end

endmodule

// File: rtl/host_seg_display.sv
// Host-mapped multiplexed 7-segment controller: synchronised write path, registered
// readback, and a tick-driven scan FSM that darkens each slot for BLANK_CYC cycles.
module host_seg_display
   import host_seg_display_pkg::*;
#(
   parameter int                CLK_HZ     = 50_000_000,
   parameter int                SCAN_HZ    = 6000,
   parameter int                NUM_DIGITS = 6,
   parameter int                BLANK_CYC  = 64,
   parameter int                ADDR_W     = 20,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h10
) (
   input  logic                  clk,
   input  logic                  nRESET,
   host_seg_display_if.slave     host,
   output logic [NUM_DIGITS-1:0] SEG_COM,
   output logic [7:0]            SEG_DATA,
   output scan_state_t           dbg_state
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [1:0]  cs_sync, we_sync;
   logic        we_prev;
   logic        in_window, wr_strobe, rd_sel;
   logic [1:0]  sel;
   logic [15:0] dig_lo, dig_hi, rd_mux;
   logic        ctrl_en, ctrl_hex;
   logic [7:0]  dp_mask, blank_mask;

   // Window is 8 bytes, so only bits above bit 2 take part in the match
   assign in_window = ((host.HOST_ADD ^ BASE_ADDR) >> 3) == '0;
   assign sel       = host.HOST_ADD[2:1];
   assign wr_strobe = we_prev && !we_sync[1] && !cs_sync[1] && host.HOST_nOE && in_window;
   assign rd_sel    = !host.HOST_nCS && !host.HOST_nOE && in_window;

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         cs_sync <= 2'b11;
         we_sync <= 2'b11;
         we_prev <= 1'b1;
      end else begin
         cs_sync <= {cs_sync[0], host.HOST_nCS};
         we_sync <= {we_sync[0], host.HOST_nWE};
         we_prev <= we_sync[1];
      end
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         dig_lo     <= '0;
         dig_hi     <= '0;
         ctrl_en    <= 1'b0;
         ctrl_hex   <= 1'b0;
         dp_mask    <= '0;
         blank_mask <= '0;
      end else if (wr_strobe) begin
         case (sel)
            OFF_DIG_LO: dig_lo <= host.HDI;
            OFF_DIG_HI: dig_hi <= host.HDI;
            OFF_CTRL: begin
               ctrl_en  <= host.HDI[CTRL_EN];
               ctrl_hex <= host.HDI[CTRL_HEX];
            end
            OFF_MASKS: begin
               dp_mask    <= host.HDI[7:0];
               blank_mask <= host.HDI[15:8];
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (sel)
         OFF_DIG_LO: rd_mux = dig_lo;
         OFF_DIG_HI: rd_mux = dig_hi;
         OFF_CTRL:   rd_mux = {14'd0, ctrl_hex, ctrl_en};
         OFF_MASKS:  rd_mux = {blank_mask, dp_mask};
      endcase
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         host.rd_hit  <= 1'b0;
         host.rd_data <= '0;
      end else begin
         host.rd_hit  <= rd_sel;
         host.rd_data <= rd_sel ? rd_mux : '0;
      end
   end

   // Scan engine
   scan_state_t           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            idx_q, idx_d;
   logic [NUM_DIGITS-1:0] com_d;
   logic [7:0]            data_d;
   logic [3:0]            cur_nib;
   logic [6:0]            cur_glyph;

   always_comb begin
      cur_nib = '0;
      case (idx_q)
         3'd0: cur_nib = dig_lo[3:0];
         3'd1: cur_nib = dig_lo[7:4];
         3'd2: cur_nib = dig_lo[11:8];
         3'd3: cur_nib = dig_lo[15:12];
         3'd4: cur_nib = dig_hi[3:0];
         3'd5: cur_nib = dig_hi[7:4];
         3'd6: cur_nib = dig_hi[11:8];
         3'd7: cur_nib = dig_hi[15:12];
      endcase
   end

   seg7_decode u_decode (
      .nibble   (cur_nib),
      .hex_mode (ctrl_hex),
      .glyph    (cur_glyph)
   );

   // Digit content is sampled only at the load point, so host writes never tear a slot
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      com_d   = SEG_COM;
      data_d  = SEG_DATA;
      if (!ctrl_en) begin
         state_d = ST_BLANK;
         cnt_d   = '0;
         idx_d   = '0;
         com_d   = '1;
         data_d  = '0;
      end else if (cnt_q == CNT_W'(DIV - 1)) begin
         state_d = ST_BLANK;
         cnt_d   = '0;
         idx_d   = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         com_d   = '1;
         data_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         if (state_q == ST_BLANK && cnt_q == CNT_W'(BLANK_CYC - 1)) begin
            state_d = ST_SHOW;
            if (!blank_mask[idx_q]) begin
               com_d  = ~(NUM_DIGITS'(1) << idx_q);
               data_d = {cur_glyph, dp_mask[idx_q]};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q  <= ST_BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         SEG_COM  <= '1;
         SEG_DATA <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         SEG_COM  <= com_d;
         SEG_DATA <= data_d;
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_host_seg_display.sv
// Directed bench for host_seg_display with DIV=10, BLANK_CYC=3, six digits; expected
// readback and slot contents come from a shadow register model and a reference glyph table.
module tb_host_seg_display;
   import host_seg_display_pkg::*;

   localparam int          ND   = 6;
   localparam logic [19:0] BASE = 20'h00010;

   logic          clk = 1'b0;
   logic          nRESET;
   logic [ND-1:0] SEG_COM;
   logic [7:0]    SEG_DATA;
   scan_state_t   dbg_state;

   host_seg_display_if #(.ADDR_W(20)) bus ();

   host_seg_display #(
      .CLK_HZ     (1000),
      .SCAN_HZ    (100),
      .NUM_DIGITS (ND),
      .BLANK_CYC  (3),
      .ADDR_W     (20),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk       (clk),
      .nRESET    (nRESET),
      .host      (bus),
      .SEG_COM   (SEG_COM),
      .SEG_DATA  (SEG_DATA),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [16:0] exp_q[$];
   logic [15:0] sh_lo, sh_hi, sh_ctrl, sh_masks;

   function automatic logic [6:0] ref_glyph(input logic [3:0] n, input logic hex);
      if (n > 4'd9 && !hex) return 7'b0000000;
      case (n)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   function automatic logic [7:0] ref_seg(input int d);
      logic [31:0] all_dig;
      logic [3:0]  nib;
      all_dig = {sh_hi, sh_lo};
      nib     = 4'((all_dig >> (4 * d)) & 32'hF);
      return {ref_glyph(nib, sh_ctrl[1]), sh_masks[d]};
   endfunction

   function automatic logic [5:0] ref_com(input int d);
      return ~(6'd1 << d);
   endfunction

   function automatic void model_write(input logic [19:0] a, input logic [15:0] d);
      if ((a >> 3) == (BASE >> 3)) begin
         case (a[2:1])
            2'd0: sh_lo = d;
            2'd1: sh_hi = d;
            2'd2: sh_ctrl = {14'd0, d[1:0]};
            default: sh_masks = d;
         endcase
      end
   endfunction

   function automatic logic [16:0] model_read(input logic [19:0] a);
      if ((a >> 3) != (BASE >> 3)) return 17'h0;
      case (a[2:1])
         2'd0: return {1'b1, sh_lo};
         2'd1: return {1'b1, sh_hi};
         2'd2: return {1'b1, sh_ctrl};
         default: return {1'b1, sh_masks};
      endcase
   endfunction

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [16:0] obs);
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed %h expected <nothing queued>", tag, obs);
      end else begin
         check(tag, obs, exp_q.pop_front());
      end
   endtask

   task automatic timeout_fail(input string tag);
      vectors++;
      miscompares++;
      $error("FAIL %s: observed timeout expected digit load", tag);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
   endtask

   task automatic host_write(input logic [19:0] a, input logic [15:0] d, input int hold);
      @(negedge clk);
      bus.HOST_ADD = a;
      bus.HDI      = d;
      bus.HOST_nCS = 1'b0;
      bus.HOST_nWE = 1'b0;
      repeat (hold) @(negedge clk);
      bus.HOST_nWE = 1'b1;
      bus.HOST_nCS = 1'b1;
      model_write(a, d);
      repeat (4) @(negedge clk);
   endtask

   task automatic host_read(input logic [19:0] a, input string tag);
      exp_q.push_back(model_read(a));
      @(negedge clk);
      bus.HOST_ADD = a;
      bus.HOST_nCS = 1'b0;
      bus.HOST_nOE = 1'b0;
      @(negedge clk);
      check_pop(tag, {bus.rd_hit, bus.rd_data});
      bus.HOST_nCS = 1'b1;
      bus.HOST_nOE = 1'b1;
   endtask

   task automatic read_all(input string tag);
      for (int k = 0; k < 4; k++) host_read(BASE + 20'(2 * k), $sformatf("%s_%0d", tag, k));
   endtask

   // Waits for the current slot to end, then for the next digit to light; counts dark samples
   task automatic expect_load(input int d, input string tag, input int exp_dark);
      int n = 0;
      int dark = 0;
      exp_q.push_back({3'b0, ref_com(d), ref_seg(d)});
      while (SEG_COM != '1 && n < 100) begin @(negedge clk); n++; end
      while (SEG_COM == '1 && n < 100) begin @(negedge clk); n++; dark++; end
      if (n >= 100) timeout_fail(tag);
      else begin
         check_pop(tag, {3'b0, SEG_COM, SEG_DATA});
         if (exp_dark != 0) check({tag, "_dark"}, 17'(dark), 17'(exp_dark));
      end
   endtask

   task automatic wait_digit(input int d, input string tag);
      int n = 0;
      exp_q.push_back({3'b0, ref_com(d), ref_seg(d)});
      while (SEG_COM != '1 && n < 150) begin @(negedge clk); n++; end
      while (SEG_COM != ref_com(d) && n < 150) begin @(negedge clk); n++; end
      if (n >= 150) timeout_fail(tag);
      else check_pop(tag, {3'b0, SEG_COM, SEG_DATA});
   endtask

   // Sets enable with a hand-driven strobe so the first digit-0 load can be timed from nWE fall
   task automatic enable_first(input string tag);
      int n = 0;
      sh_ctrl = 16'h0001;
      exp_q.push_back({3'b0, ref_com(0), ref_seg(0)});
      @(negedge clk);
      bus.HOST_ADD = BASE + 20'd4;
      bus.HDI      = 16'h0001;
      bus.HOST_nCS = 1'b0;
      bus.HOST_nWE = 1'b0;
      while (SEG_COM == '1 && n < 20) begin @(negedge clk); n++; end
      check({tag, "_latency"}, 17'(n), 17'd6);
      check_pop(tag, {3'b0, SEG_COM, SEG_DATA});
      bus.HOST_nWE = 1'b1;
      bus.HOST_nCS = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      bus.HOST_nCS = 1'b1;
      bus.HOST_nWE = 1'b1;
      bus.HOST_nOE = 1'b1;
      bus.HOST_ADD = '0;
      bus.HDI      = '0;
      sh_lo = '0; sh_hi = '0; sh_ctrl = '0; sh_masks = '0;
      nRESET = 1'b0;
      repeat (3) @(negedge clk);
      nRESET = 1'b1;
      @(negedge clk);

      check("rst_com", 17'(SEG_COM), 17'h3F);
      check("rst_data", 17'(SEG_DATA), 17'h0);
      check("rst_state", 17'(dbg_state), 17'(ST_BLANK));
      check("rst_rd_hit", 17'(bus.rd_hit), 17'h0);
      read_all("rst_rd");

      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (SEG_COM != '1 || SEG_DATA != 8'h00) bad++;
      end
      check("disabled_dark", 17'(bad), 17'h0);

      // Scan sequence and slot timing
      host_write(BASE, 16'h4321, 4);
      enable_first("en_dig0");
      expect_load(1, "scan_dig1", 3);
      expect_load(2, "scan_dig2", 3);
      expect_load(3, "scan_dig3", 3);
      expect_load(4, "scan_dig4", 3);
      expect_load(5, "scan_dig5", 3);
      expect_load(0, "scan_wrap0", 3);

      // Decimal versus hex glyphs
      host_write(BASE + 20'd2, 16'h00FA, 4);
      wait_digit(4, "dec_A_dark");
      wait_digit(5, "dec_F_dark");
      host_write(BASE + 20'd4, 16'h0003, 4);
      wait_digit(4, "hex_A");
      wait_digit(5, "hex_F");
      wait_digit(3, "hex_dig3");

      // dp on digit 0, digit 1 blanked for its whole slot
      host_write(BASE + 20'd6, 16'h0201, 4);
      wait_digit(0, "dp_dig0");
      expect_load(2, "blank_skip", 13);
      host_write(BASE + 20'd6, 16'h0000, 4);

      // One long strobe; data changed late must not land as a second write
      @(negedge clk);
      bus.HOST_ADD = BASE;
      bus.HDI      = 16'h5A5A;
      bus.HOST_nCS = 1'b0;
      bus.HOST_nWE = 1'b0;
      repeat (10) @(negedge clk);
      bus.HDI = 16'hFFFF;
      repeat (10) @(negedge clk);
      bus.HOST_nWE = 1'b1;
      bus.HOST_nCS = 1'b1;
      model_write(BASE, 16'h5A5A);
      repeat (4) @(negedge clk);
      host_read(BASE, "single_write");

      host_write(BASE + 20'd8, 16'hBEEF, 4);
      read_all("unmapped_wr");

      @(negedge clk);
      bus.HOST_ADD = BASE + 20'd2;
      bus.HDI      = 16'h1234;
      bus.HOST_nCS = 1'b0;
      bus.HOST_nOE = 1'b0;
      bus.HOST_nWE = 1'b0;
      repeat (6) @(negedge clk);
      bus.HOST_nWE = 1'b1;
      bus.HOST_nOE = 1'b1;
      bus.HOST_nCS = 1'b1;
      repeat (4) @(negedge clk);
      host_read(BASE + 20'd2, "noe_blocks_wr");

      // Readback, reserved CTRL bits, out-of-window reads
      host_write(BASE + 20'd6, 16'hA55A, 4);
      host_write(BASE + 20'd4, 16'hFFFD, 4);
      read_all("readback");
      host_read(BASE + 20'd8, "rd_out_hi");
      host_read(20'h00000, "rd_out_zero");
      host_write(BASE + 20'd6, 16'h0000, 4);
      host_write(BASE + 20'd4, 16'h0001, 4);

      // Asynchronous reset while a digit is lit
      bad = 0;
      while (SEG_COM == '1 && bad < 40) begin @(negedge clk); bad++; end
      check("pre_reset_lit", 17'(SEG_COM == '1), 17'h0);
      #2 nRESET = 1'b0;
      #1;
      check("async_rst_com", 17'(SEG_COM), 17'h3F);
      check("async_rst_data", 17'(SEG_DATA), 17'h0);
      @(negedge clk);
      nRESET = 1'b1;
      sh_lo = '0; sh_hi = '0; sh_ctrl = '0; sh_masks = '0;
      read_all("post_rst");
      host_write(BASE, 16'h9876, 4);
      enable_first("restart_dig0");
      expect_load(1, "restart_dig1", 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
